nttn_host_sequencer: RTL and testbench
======================================

Name: nttn_host_sequencer

Overview:
- Host-side initiator for the NTTN core: accepts ops on a command handshake, streams twiddles and params or polynomial coefficients from a valid/ready source into NTTN, pulses start or start_intt, then captures NTTN's post-done output burst onto a result stream.
- Sits between the DMA/BRAM fabric and NTTN. It is the only driver of NTTN's load_w, load_data, start, start_intt and din.

Parameters:
- DATA_SIZE_ARB, 64: coefficient width.
- RING_DEPTH, 10: log2 of RING_SIZE.
- PE_DEPTH, 3: log2 of PE count.
- GAP, 5: idle cycles between end of data stream and start pulse.
- TIMEOUT, 1048576: maximum cycles to wait for nttn_done.
- Derived W_COUNT = ((2^(RING_DEPTH-PE_DEPTH)-1)+PE_DEPTH) << PE_DEPTH. This is 1040 at the defaults.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  2  0=LOADW, 1=NTT, 2=INTT, 3=reserved.
- s_data  in  DATA_SIZE_ARB  source word.
- s_valid  in  1  source word valid.
- s_ready  out  1  sequencer consuming a source word this cycle.
- m_data  out  DATA_SIZE_ARB  result word.
- m_valid  out  1  result word valid; no backpressure.
- m_last  out  1  marks the final result word.
- busy  out  1  high whenever state is not IDLE.
- err  out  3  sticky flags: [0] underflow, [1] timeout, [2] bad command.
- err_clr  in  1  clears err.
- nttn_load_w, nttn_load_data, nttn_start, nttn_start_intt  out  1 each  one-cycle pulses to NTTN.
- nttn_din  out  DATA_SIZE_ARB  NTTN data input.
- nttn_done  in  1  NTTN done pulse.
- nttn_dout  in  DATA_SIZE_ARB  NTTN output word.

Behaviour:

Reset and idle levels
- reset=0 at a clk edge: state=IDLE, all counters cleared, w_loaded=0, err=0.
- Every output is 0 during and after reset, except cmd_ready, which is 1 from the first cycle after reset deasserts.
- Reset mid-operation aborts the op immediately with no further pulses. NTTN shares the same reset.

FSM
- States: IDLE, PULSE, STREAM, GAPW, START, WAITD, COLLECT.
- Command accepted at cycle c (cmd_valid and cmd_ready):
  - op 3 → err[2] set, stay IDLE.
  - NTT or INTT with w_loaded=0 → err[2] set, stay IDLE.
  - Otherwise go to PULSE.
- PULSE (c+1): assert nttn_load_w for LOADW, else nttn_load_data. Load length is N = 2*W_COUNT+2 for LOADW, else N = RING_SIZE.
- STREAM (c+2 … c+1+N):
  - s_ready=1 for exactly N consecutive cycles.
  - nttn_din = s_data combinationally while s_ready=1; 0 otherwise.
  - NTTN cannot pause, so the stream never stalls. If s_valid=0 in any STREAM cycle: set err[0], drive nttn_din=0, keep counting.
- After STREAM:
  - LOADW → set w_loaded=1, go to IDLE.
  - Otherwise go to GAPW for GAP cycles, then START for one cycle, asserting nttn_start (op 1) or nttn_start_intt (op 2).
- WAITD:
  - Count cycles. When nttn_done is seen at cycle t, go to COLLECT.
  - If the count reaches TIMEOUT → set err[1], go to IDLE, emit no m_valid.
- COLLECT:
  - NTTN word k is on nttn_dout at t+1+k. It is registered, so m_data=word k and m_valid=1 at t+2+k, for k = 0 … RING_SIZE-1.
  - m_last=1 with k=RING_SIZE-1. IDLE (cmd_ready=1) on the following cycle.
- nttn_done outside WAITD is ignored.

Errors and counters
- Error flags are sticky. If err_clr and a new error set occur in the same cycle, set wins.
- The stream counter wraps cleanly to 0 at the end of every stream; no off-by-one between N and the s_ready cycle count.
- w_loaded persists across NTT/INTT ops. Only reset clears it.

Test Plan:
1. RING_DEPTH=4, PE_DEPTH=1 (W_COUNT=16), LOADW with a continuous source → one nttn_load_w pulse, then s_ready high for exactly 34 cycles, nttn_din matching s_data each cycle, w_loaded=1, err=0.
2. After test 1, NTT with 16 source words; NTTN model asserts done 40 cycles after start → nttn_start lands exactly GAP+1=6 cycles after the last s_ready; m_valid high for exactly 16 cycles beginning 2 cycles after done; m_data equals model output in order; m_last on word 15.
3. Immediately after reset, issue NTT, and separately issue op 3 → err=3'b100, no NTTN pulses, cmd_ready stays 1; err_clr → err=0.
4. INTT with s_valid dropped for 2 cycles mid-stream → err[0]=1, stream still exactly 16 cycles, nttn_din=0 in the dropped cycles, nttn_start_intt still issued.
5. TIMEOUT=64, model never asserts done → err[1]=1 after 64 WAITD cycles, return to IDLE, m_valid never asserted.
6. Assert reset=0 during COLLECT at word 7 → next cycle all outputs 0; w_loaded=0 after release; stray nttn_done afterwards produces no m_valid.

Source files
------------

// File: rtl/nttn_host_sequencer.sv
// Host-side initiator for NTTN: takes commands, streams twiddles or coefficients into
// NTTN, pulses start/start_intt, then forwards NTTN's post-done burst to a result stream.
module nttn_host_sequencer #(
  parameter int DATA_SIZE_ARB = 64,
  parameter int RING_DEPTH    = 10,
  parameter int PE_DEPTH      = 3,
  parameter int GAP           = 5,
  parameter int TIMEOUT       = 1048576
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [DATA_SIZE_ARB-1:0] s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic [DATA_SIZE_ARB-1:0] m_data,
  output logic                     m_valid,
  output logic                     m_last,
  output logic                     busy,
  output logic [2:0]               err,
  input  logic                     err_clr,
  output logic                     nttn_load_w,
  output logic                     nttn_load_data,
  output logic                     nttn_start,
  output logic                     nttn_start_intt,
  output logic [DATA_SIZE_ARB-1:0] nttn_din,
  input  logic                     nttn_done,
  input  logic [DATA_SIZE_ARB-1:0] nttn_dout,
  output logic [2:0]               dbg_state
);

  localparam int RING_SIZE = 1 << RING_DEPTH;
  localparam int W_COUNT   = ((2 ** (RING_DEPTH - PE_DEPTH) - 1) + PE_DEPTH) << PE_DEPTH;
  localparam int LOADW_N   = 2 * W_COUNT + 2;
  localparam int MAX_A     = (LOADW_N > RING_SIZE + 1) ? LOADW_N : RING_SIZE + 1;
  localparam int MAX_B     = (GAP > TIMEOUT) ? GAP : TIMEOUT;
  localparam int MAX_C     = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W     = $clog2(MAX_C + 1);
  localparam int GAP_LAST  = (GAP > 0) ? GAP - 1 : 0;

  localparam logic [1:0] OP_LOADW = 2'd0;
  localparam logic [1:0] OP_NTT   = 2'd1;
  localparam logic [1:0] OP_INTT  = 2'd2;
  localparam logic [1:0] OP_RSVD  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PULSE   = 3'd1,
    S_STREAM  = 3'd2,
    S_GAPW    = 3'd3,
    S_START   = 3'd4,
    S_WAITD   = 3'd5,
    S_COLLECT = 3'd6
  } state_t;

  state_t                     state, state_next;
  logic [1:0]                 op_q;
  logic [CNT_W-1:0]           cnt;
  logic                       w_loaded;
  logic                       w_set;
  logic [2:0]                 err_q, err_set;
  logic [DATA_SIZE_ARB-1:0]   m_data_q;
  logic                       m_valid_q, m_last_q;
  logic                       accept;
  logic                       collect_cap;
  logic [CNT_W-1:0]           stream_last;

  // Handshakes: a word/command transfers on a clock edge where valid and ready are both
  // high. s_ready never waits for s_valid (NTTN cannot pause); a missing word is an error.
  assign accept      = cmd_valid & cmd_ready;
  assign stream_last = (op_q == OP_LOADW) ? CNT_W'(LOADW_N - 1) : CNT_W'(RING_SIZE - 1);
  // COLLECT spends RING_SIZE cycles capturing and one more presenting m_last.
  assign collect_cap = (state == S_COLLECT) && (cnt < CNT_W'(RING_SIZE));

  always_comb begin
    state_next      = state;
    err_set         = 3'b000;
    w_set           = 1'b0;
    cmd_ready       = 1'b0;
    s_ready         = 1'b0;
    nttn_load_w     = 1'b0;
    nttn_load_data  = 1'b0;
    nttn_start      = 1'b0;
    nttn_start_intt = 1'b0;
    nttn_din        = '0;
    if (reset) begin
      case (state)
        S_IDLE: begin
          cmd_ready = 1'b1;
          if (cmd_valid) begin
            if (cmd_op == OP_RSVD || (cmd_op != OP_LOADW && !w_loaded)) err_set[2] = 1'b1;
            else state_next = S_PULSE;
          end
        end
        S_PULSE: begin
          nttn_load_w    = (op_q == OP_LOADW);
          nttn_load_data = (op_q != OP_LOADW);
          state_next     = S_STREAM;
        end
        S_STREAM: begin
          s_ready  = 1'b1;
          nttn_din = s_valid ? s_data : '0;
          if (!s_valid) err_set[0] = 1'b1;
          if (cnt == stream_last) begin
            if (op_q == OP_LOADW) begin
              w_set      = 1'b1;
              state_next = S_IDLE;
            end else if (GAP == 0) begin
              state_next = S_START;
            end else begin
              state_next = S_GAPW;
            end
          end
        end
        S_GAPW: begin
          if (cnt == CNT_W'(GAP_LAST)) state_next = S_START;
        end
        S_START: begin
          nttn_start      = (op_q == OP_NTT);
          nttn_start_intt = (op_q == OP_INTT);
          state_next      = S_WAITD;
        end
        S_WAITD: begin
          if (nttn_done) begin
            state_next = S_COLLECT;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            err_set[1] = 1'b1;
            state_next = S_IDLE;
          end
        end
        S_COLLECT: begin
          if (cnt == CNT_W'(RING_SIZE)) state_next = S_IDLE;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      op_q      <= OP_LOADW;
      cnt       <= '0;
      w_loaded  <= 1'b0;
      err_q     <= 3'b000;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
    end else begin
      state <= state_next;
      // One counter serves every timed state; it restarts at 0 on each state change.
      if (state_next != state || state == S_IDLE) cnt <= '0;
      else cnt <= cnt + CNT_W'(1);
      if (accept) op_q <= cmd_op;
      if (w_set) w_loaded <= 1'b1;
      err_q     <= (err_q & ~{3{err_clr}}) | err_set;
      m_valid_q <= collect_cap;
      m_last_q  <= collect_cap && (cnt == CNT_W'(RING_SIZE - 1));
      m_data_q  <= collect_cap ? nttn_dout : '0;
    end
  end

  assign m_data    = reset ? m_data_q : '0;
  assign m_valid   = reset & m_valid_q;
  assign m_last    = reset & m_last_q;
  assign err       = reset ? err_q : 3'b000;
  assign busy      = reset && (state != S_IDLE);
  assign dbg_state = state;

  // op_q[1:0] is fully decoded; op 3 never leaves IDLE.
  logic unused_ok;
  assign unused_ok = &{1'b0, OP_INTT};

endmodule

// File: tb/tb_nttn_host_sequencer.sv
// Directed bench for nttn_host_sequencer: table of ops with hand-derived expectations,
// an NTTN response model, and hand sequences for reset-during-collect and stray done.
module tb_nttn_host_sequencer;
  localparam int DW = 16;
  localparam int RD = 4;
  localparam int PD = 1;
  localparam int GP = 5;
  localparam int TO = 64;
  localparam int RS = 16;
  localparam int NV = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'd0;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b1;
  logic          s_ready;
  logic [DW-1:0] m_data;
  logic          m_valid, m_last, busy;
  logic [2:0]    err;
  logic          err_clr = 1'b0;
  logic          nttn_load_w, nttn_load_data, nttn_start, nttn_start_intt;
  logic [DW-1:0] nttn_din;
  logic          nttn_done = 1'b0;
  logic [DW-1:0] nttn_dout = '0;
  logic [2:0]    dbg_state;

  nttn_host_sequencer #(
    .DATA_SIZE_ARB(DW), .RING_DEPTH(RD), .PE_DEPTH(PD), .GAP(GP), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .busy(busy), .err(err),
    .err_clr(err_clr), .nttn_load_w(nttn_load_w), .nttn_load_data(nttn_load_data),
    .nttn_start(nttn_start), .nttn_start_intt(nttn_start_intt), .nttn_din(nttn_din),
    .nttn_done(nttn_done), .nttn_dout(nttn_dout), .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // stimulus controls, written only by the main initial block
  int op_id = 0;
  int tag = 0;
  logic drop_en = 1'b0;
  int done_delay = 0;
  int stray_cyc = -1;

  // observations, written only by the monitor
  int cyc = 0;
  int seen_id = 0;
  int done_cyc = -1000;
  int acc_cyc, pulse_cyc, first_sr, last_sr, start_cyc, last_busy, mlast_cyc;
  int n_loadw, n_loaddata, n_start, n_intt, stream_cnt, dropped, din_bad;
  int m_cnt, m_bad, busy_cnt, rdy_low;

  // expected result queue for the current op's output burst
  logic [DW-1:0] exp_q[$];

  function automatic logic [DW-1:0] model_word(input int k);
    return DW'(tag * 97 + k * 13 + 5);
  endfunction

  // source and NTTN model drive their inputs just after each rising edge
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    s_data    = DW'($urandom_range(0, 65535));
    s_valid   = !(drop_en && stream_cnt >= 5 && stream_cnt <= 6);
    nttn_done = (cyc == done_cyc) || (cyc == stray_cyc);
    nttn_dout = (cyc > done_cyc && cyc <= done_cyc + RS) ? model_word(cyc - done_cyc - 1)
                                                         : DW'($urandom_range(0, 65535));
  end

  // monitor samples on the falling edge
  always @(negedge clk) begin
    if (op_id != seen_id) begin
      seen_id = op_id;
      acc_cyc = -1; pulse_cyc = -1; first_sr = -1; last_sr = -1; start_cyc = -1;
      last_busy = -1; mlast_cyc = -1; done_cyc = -1000;
      n_loadw = 0; n_loaddata = 0; n_start = 0; n_intt = 0; stream_cnt = 0;
      dropped = 0; din_bad = 0; m_cnt = 0; m_bad = 0; busy_cnt = 0; rdy_low = 0;
      exp_q.delete();
    end
    if (reset) begin
      if (cmd_valid && cmd_ready) acc_cyc = cyc;
      if (!cmd_ready) rdy_low++;
      if (busy) begin busy_cnt++; last_busy = cyc; end
      if (nttn_load_w) begin n_loadw++; pulse_cyc = cyc; end
      if (nttn_load_data) begin n_loaddata++; pulse_cyc = cyc; end
      if (nttn_start) n_start++;
      if (nttn_start_intt) n_intt++;
      if (nttn_start || nttn_start_intt) begin
        start_cyc = cyc;
        if (done_delay > 0) begin
          done_cyc = cyc + done_delay;
          for (int k = 0; k < RS; k++) exp_q.push_back(model_word(k));
        end
      end
      if (s_ready) begin
        if (stream_cnt == 0) first_sr = cyc;
        last_sr = cyc;
        if (nttn_din !== (s_valid ? s_data : DW'(0))) din_bad++;
        if (!s_valid) dropped++;
        stream_cnt++;
      end else if (nttn_din !== DW'(0)) begin
        din_bad++;
      end
      if (m_valid) begin
        if (exp_q.size() == 0) m_bad++;
        else if (m_data !== exp_q.pop_front()) m_bad++;
        if (cyc != done_cyc + 2 + m_cnt || m_last !== (m_cnt == RS - 1)) m_bad++;
        if (m_last) mlast_cyc = cyc;
        m_cnt++;
      end else if (m_last) begin
        m_bad++;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    check("rst_ready_low", cmd_ready, 0);
    check("rst_busy", busy, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk); #2;
    check("rst_ready", cmd_ready, 1);
    check("rst_err", err, 0);
    check("rst_outs", {m_valid, m_last, s_ready, nttn_load_w, nttn_load_data,
                       nttn_start, nttn_start_intt}, 0);
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
  endtask

  task automatic issue(input logic [1:0] op, input logic clr);
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_op    = op;
    err_clr   = clr;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    err_clr   = 1'b0;
  endtask

  task automatic wait_idle(output int ok);
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #2;
      if (!busy && i >= 3) begin ok = 1; break; end
    end
  endtask

  typedef struct {
    logic       rst;
    logic       clr_before;
    logic       clr_with;
    logic [1:0] op;
    logic       drop;
    int         delay;
    logic [2:0] err;
    int         loadw, loaddata, stream, start, intt, m;
  } vec_t;

  vec_t vec [NV];

  initial begin
    int ok;
    string p;
    vec[0] = '{1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 40, 3'b100, 0, 0, 0,  0, 0, 0};
    vec[1] = '{1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 0,  3'b100, 0, 0, 0,  0, 0, 0};
    vec[2] = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 0,  3'b000, 1, 0, 34, 0, 0, 0};
    vec[3] = '{1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 40, 3'b000, 0, 1, 16, 1, 0, 16};
    vec[4] = '{1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 30, 3'b001, 0, 1, 16, 0, 1, 16};
    vec[5] = '{1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 0,  3'b010, 0, 1, 16, 1, 0, 0};
    vec[6] = '{1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 0,  3'b100, 0, 0, 0,  0, 0, 0};
    vec[7] = '{1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 25, 3'b000, 0, 1, 16, 1, 0, 16};

    apply_reset();

    for (int r = 0; r < NV; r++) begin
      p = $sformatf("r%0d_", r);
      if (vec[r].rst) apply_reset();
      if (vec[r].clr_before) pulse_clr();
      op_id      = op_id + 1;
      tag        = r + 1;
      drop_en    = vec[r].drop;
      done_delay = vec[r].delay;
      issue(vec[r].op, vec[r].clr_with);
      wait_idle(ok);
      check({p, "idle"}, ok, 1);
      check({p, "err"}, err, vec[r].err);
      check({p, "load_w"}, n_loadw, vec[r].loadw);
      check({p, "load_data"}, n_loaddata, vec[r].loaddata);
      check({p, "stream_len"}, stream_cnt, vec[r].stream);
      check({p, "dropped"}, dropped, vec[r].drop ? 2 : 0);
      check({p, "din_bad"}, din_bad, 0);
      check({p, "start"}, n_start, vec[r].start);
      check({p, "start_intt"}, n_intt, vec[r].intt);
      check({p, "m_count"}, m_cnt, vec[r].m);
      check({p, "m_bad"}, m_bad, 0);
      if (vec[r].stream > 0) begin
        check({p, "pulse_at"}, pulse_cyc - acc_cyc, 1);
        check({p, "stream_at"}, first_sr - acc_cyc, 2);
        check({p, "stream_span"}, last_sr - first_sr + 1, vec[r].stream);
      end else begin
        check({p, "ready_low"}, rdy_low, 0);
        check({p, "busy_cycles"}, busy_cnt, 0);
      end
      if (vec[r].start + vec[r].intt > 0) check({p, "gap"}, start_cyc - last_sr, GP + 1);
      if (vec[r].m > 0) check({p, "idle_after_last"}, last_busy, mlast_cyc);
      if (vec[r].start > 0 && vec[r].m == 0) check({p, "wait_len"}, last_busy - start_cyc, TO);
    end

    // reset while word 7 of the result burst is on m_data
    op_id      = op_id + 1;
    tag        = 50;
    drop_en    = 1'b0;
    done_delay = 20;
    issue(2'd1, 1'b0);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #2;
      if (m_cnt == 8) begin ok = 1; break; end
    end
    check("mid_reach_word7", ok, 1);
    reset = 1'b0;
    @(negedge clk); #2;
    check("mid_m_valid", m_valid, 0);
    check("mid_m_data", m_data, 0);
    check("mid_busy", busy, 0);
    check("mid_ready", cmd_ready, 0);
    check("mid_state", dbg_state, 0);
    check("mid_pulses", {s_ready, nttn_load_w, nttn_load_data, nttn_start, nttn_start_intt,
                         m_last}, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk); #2;
    check("post_ready", cmd_ready, 1);
    check("post_err", err, 0);

    // w_loaded must have been cleared: NTT is now a bad command
    op_id = op_id + 1;
    issue(2'd1, 1'b0);
    wait_idle(ok);
    check("post_ntt_err", err, 4);
    check("post_ntt_load", n_loaddata, 0);

    // stray done while idle
    op_id     = op_id + 1;
    stray_cyc = cyc + 3;
    repeat (25) @(negedge clk);
    #2;
    check("stray_m_valid", m_cnt, 0);
    check("stray_busy", busy_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1, want 0");
    $fatal(1, "bench time limit");
  end
endmodule
